// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the CPU fetch port and
// instruction memory; a miss stalls the CPU and refills one block.
module instruction_cache #(
   parameter int unsigned LINES       = 8,
   parameter int unsigned BLOCK_WORDS = 4,
   parameter int unsigned ADDR_BITS   = 10
) (
   input  logic                                     CLK,
   input  logic                                     RESET,
   input  logic [31:0]                              PC,
   output logic [31:0]                              INSTRUCTION,
   output logic                                     BUSYWAIT,
   output logic                                     MEM_READ,
   output logic [ADDR_BITS-$clog2(BLOCK_WORDS)-3:0] MEM_ADDRESS,
   input  logic [32*BLOCK_WORDS-1:0]                MEM_READDATA,
   input  logic                                     MEM_BUSYWAIT
);

   localparam int unsigned WORD_W = $clog2(BLOCK_WORDS);
   localparam int unsigned OFF_W  = WORD_W + 2;
   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned TAG_W  = ADDR_BITS - OFF_W - IDX_W;

   typedef logic [BLOCK_WORDS-1:0][31:0] block_t;
   typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

   state_t            state_q, state_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];
   block_t            data_q [LINES];
   block_t            data_d [LINES];
   logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
   logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
   block_t            refill_q, refill_d;

   logic [WORD_W-1:0] pc_word;
   logic [IDX_W-1:0]  pc_idx;
   logic [TAG_W-1:0]  pc_tag;
   logic              hit;
   logic              pc_unused;

   // Address split; bits above ADDR_BITS alias onto the low address space.
   assign pc_word   = PC[OFF_W-1:2];
   assign pc_idx    = PC[OFF_W+IDX_W-1:OFF_W];
   assign pc_tag    = PC[ADDR_BITS-1:OFF_W+IDX_W];
   assign pc_unused = ^{PC[31:ADDR_BITS], PC[1:0]};

   assign hit         = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
   assign INSTRUCTION = data_q[pc_idx][pc_word];
   assign MEM_ADDRESS = {miss_tag_q, miss_idx_q};

   // Next-state, refill bookkeeping and stall/request outputs.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      data_d     = data_q;
      miss_idx_d = miss_idx_q;
      miss_tag_d = miss_tag_q;
      refill_d   = refill_q;
      BUSYWAIT   = 1'b0;
      MEM_READ   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!hit) begin
               BUSYWAIT   = 1'b1;
               miss_idx_d = pc_idx;
               miss_tag_d = pc_tag;
               state_d    = S_MEM_READ;
            end
         end
         S_MEM_READ: begin
            BUSYWAIT = 1'b1;
            MEM_READ = 1'b1;
            if (!MEM_BUSYWAIT) begin
               refill_d = MEM_READDATA;
               state_d  = S_UPDATE;
            end
         end
         S_UPDATE: begin
            BUSYWAIT            = 1'b1;
            valid_d[miss_idx_q] = 1'b1;
            tag_d[miss_idx_q]   = miss_tag_q;
            data_d[miss_idx_q]  = refill_q;
            state_d             = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (RESET) BUSYWAIT = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         valid_q    <= '0;
         tag_q      <= '{default: '0};
         data_q     <= '{default: '0};
         miss_idx_q <= '0;
         miss_tag_q <= '0;
         refill_q   <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         data_q     <= data_d;
         miss_idx_q <= miss_idx_d;
         miss_tag_q <= miss_tag_d;
         refill_q   <= refill_d;
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: a driver issues fetches and predicts
// hit/miss from a line-level cache model; a negedge monitor checks responses.
module tb_instruction_cache;

   logic         clk;
   logic         rst;
   logic [31:0]  pc;
   logic [31:0]  instr;
   logic         busywait;
   logic         mem_read;
   logic [5:0]   mem_addr;
   logic [127:0] mem_rdata;
   logic         mem_busy;

   instruction_cache dut (
      .CLK          (clk),
      .RESET        (rst),
      .PC           (pc),
      .INSTRUCTION  (instr),
      .BUSYWAIT     (busywait),
      .MEM_READ     (mem_read),
      .MEM_ADDRESS  (mem_addr),
      .MEM_READDATA (mem_rdata),
      .MEM_BUSYWAIT (mem_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: 256 words, busy for mem_lat cycles of each request.
   logic [31:0] mem_words [256];
   int          mem_lat;
   int          mem_cnt;

   always_comb begin
      for (int w = 0; w < 4; w++) mem_rdata[32*w +: 32] = mem_words[{mem_addr, 2'(w)}];
   end
   assign mem_busy = mem_read && (mem_cnt < mem_lat);

   always @(posedge clk) begin
      if (mem_read) mem_cnt <= mem_cnt + 1;
      else          mem_cnt <= 0;
   end

   // Reference cache model and scoreboard queues.
   bit          ref_valid [8];
   int unsigned ref_tag   [8];

   typedef struct { logic [31:0] instr; int stall; } fexp_t;
   typedef struct { int addr; int cycles; } mexp_t;
   fexp_t fq[$];
   mexp_t mq[$];

   int  n_checks;
   int  n_pass;
   bit  sb_en;
   int  busy_cnt;
   int  rd_cnt;
   int  cur_rd_cycles;
   fexp_t f_cur;
   mexp_t m_cur;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      $display("FAIL %s: bound of 100 cycles expired (t=%0t)", name, $time);
   endtask

   // Monitor: checks every memory request and every completed fetch.
   always @(negedge clk) begin
      if (rst || !sb_en) begin
         busy_cnt = 0;
         rd_cnt   = 0;
      end else begin
         if (mem_read) begin
            if (rd_cnt == 0) begin
               check("mem_read_expected", 32'(mq.size() != 0), 32'd1);
               if (mq.size() != 0) begin
                  m_cur = mq.pop_front();
                  check("mem_address", 32'(mem_addr), 32'(m_cur.addr));
                  cur_rd_cycles = m_cur.cycles;
               end
            end
            rd_cnt++;
         end else if (rd_cnt != 0) begin
            check("mem_read_cycles", 32'(rd_cnt), 32'(cur_rd_cycles));
            rd_cnt = 0;
         end
         if (fq.size() != 0) begin
            if (busywait) busy_cnt++;
            else begin
               f_cur = fq.pop_front();
               check("instruction", instr, f_cur.instr);
               check("busywait_cycles", 32'(busy_cnt), 32'(f_cur.stall));
               busy_cnt = 0;
            end
         end
      end
   end

   // Reset for two edges, checking the cleared outputs while RESET is held.
   task automatic do_reset();
      sb_en = 1'b0;
      rst   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset_busywait", 32'(busywait), 32'd0);
      check("reset_mem_read", 32'(mem_read), 32'd0);
      check("reset_mem_address", 32'(mem_addr), 32'd0);
      check("reset_instruction", instr, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ref_valid[i] = 1'b0;
         ref_tag[i]   = 0;
      end
      fq.delete();
      mq.delete();
      sb_en = 1'b1;
   endtask

   // One CPU fetch: predict from the model, hold PC until BUSYWAIT drops.
   task automatic fetch(input logic [31:0] addr, input int lat);
      int unsigned a, idx, tg;
      bit h;
      int n;
      a   = addr % 32'd1024;
      idx = (a / 16) % 8;
      tg  = a / 128;
      h   = ref_valid[idx] && (ref_tag[idx] == tg);
      if (!h) begin
         mq.push_back('{int'(a / 16), lat + 1});
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tg;
      end
      fq.push_back('{mem_words[a / 4], h ? 0 : lat + 3});
      mem_lat = lat;
      pc      = addr;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busywait && n < 100);
      if (busywait) timeout_fail("fetch_wait");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mem_read_rise();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_read && n < 100);
      if (!mem_read) timeout_fail("mem_read_wait");
   endtask

   task automatic wait_ready();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busywait && n < 100);
      if (busywait) timeout_fail("ready_wait");
   endtask

   logic [31:0] rpc;
   logic [31:0] pa, pb;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      sb_en    = 1'b0;
      mem_lat  = 1;
      pc       = 32'h0;
      rst      = 1'b1;
      for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
      mem_words[0] = 32'd1;
      mem_words[1] = 32'd2;
      mem_words[2] = 32'd3;
      mem_words[3] = 32'd4;

      // Cold miss with 4 busy cycles, then hits in the same block and an alias.
      do_reset();
      fetch(32'h000, 4);
      fetch(32'h004, 3);
      fetch(32'h008, 3);
      fetch(32'h00C, 3);
      fetch(32'h400, 3);

      // Conflict misses on index 0, then fill and re-fetch indices 1-7.
      do_reset();
      fetch(32'h000, 2);
      fetch(32'h080, 1);
      fetch(32'h000, 3);
      for (int i = 1; i < 8; i++) fetch(32'(i * 16), $urandom_range(1, 4));
      for (int i = 1; i < 8; i++) fetch(32'(i * 16 + 4 * $urandom_range(0, 3)), 2);

      // Randomized fetches, sometimes with junk above the address bits.
      for (int k = 0; k < 80; k++) begin
         rpc = 32'($urandom_range(0, 127)) << 2;
         if ($urandom_range(0, 3) == 0) rpc = rpc | (32'($urandom) & 32'hFFFF_FC00);
         fetch(rpc, $urandom_range(1, 5));
      end
      repeat (3) @(negedge clk);
      check("fetch_queue_drained", 32'(fq.size()), 32'd0);
      check("mem_queue_drained", 32'(mq.size()), 32'd0);

      // RESET in the third MEM_READ cycle aborts the refill.
      do_reset();
      sb_en   = 1'b0;
      mem_lat = 6;
      pc      = 32'h020;
      wait_mem_read_rise();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort_busywait_in_reset", 32'(busywait), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_mem_read", 32'(mem_read), 32'd0);
      check("abort_instruction", instr, 32'd0);
      check("abort_mem_address", 32'(mem_addr), 32'd0);
      check("abort_refetch_misses", 32'(busywait), 32'd1);
      wait_mem_read_rise();
      check("abort_refetch_address", 32'(mem_addr), 32'd2);
      wait_ready();
      check("abort_refetch_data", instr, mem_words[8]);
      @(posedge clk);
      #1;

      // PC moves during MEM_READ: original block still fills, new PC then misses.
      do_reset();
      sb_en   = 1'b0;
      pa      = 32'h134;
      pb      = 32'h2C8;
      mem_lat = 4;
      pc      = pa;
      wait_mem_read_rise();
      check("pcmove_first_address", 32'(mem_addr), 32'(pa[9:4]));
      @(posedge clk);
      #1;
      pc = pb;
      while (mem_read) begin
         @(negedge clk);
         if (mem_read) check("pcmove_address_held", 32'(mem_addr), 32'(pa[9:4]));
      end
      wait_mem_read_rise();
      check("pcmove_second_address", 32'(mem_addr), 32'(pb[9:4]));
      wait_ready();
      check("pcmove_new_data", instr, mem_words[pb[9:2]]);
      @(posedge clk);
      #1;
      pc = pa;
      @(negedge clk);
      check("pcmove_old_line_hit", 32'(busywait), 32'd0);
      check("pcmove_old_line_data", instr, mem_words[pa[9:2]]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
